// File: rtl/uart_reg_bridge.sv
// Bridges UART rx/tx FIFOs to an 8-bit register bus using a tiny byte protocol:
// 'W' addr data -> 'K', 'R' addr -> data, anything else -> 'E'.
module uart_reg_bridge #(
  parameter logic [7:0] CMD_WR  = 8'h57,
  parameter logic [7:0] CMD_RD  = 8'h52,
  parameter logic [7:0] RSP_ACK = 8'h4B,
  parameter logic [7:0] RSP_NAK = 8'h45,
  parameter int         TIMEOUT = 1000000,
  parameter int         TO_BIT  = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  input  logic       tx_full,
  output logic [7:0] w_data,
  output logic       wr_uart,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, RD_WAIT, SEND
  } state_t;

  // Timeout fires on the cycle the counter would step onto TIMEOUT-1.
  localparam logic [TO_BIT-1:0] TO_LAST = TO_BIT'(TIMEOUT - 2);

  state_t            state_q, state_d;
  logic              mode_wr_q, mode_wr_d;
  logic [TO_BIT-1:0] cnt_q, cnt_d;
  logic [7:0]        w_data_q, w_data_d;
  logic [7:0]        reg_addr_q, reg_addr_d;
  logic [7:0]        reg_wdata_q, reg_wdata_d;
  logic              reg_we_q, reg_we_d;
  logic              reg_re_q, reg_re_d;
  logic              frame_err_q, frame_err_d;
  logic              pop, to_hit;

  assign pop    = !rst && !rx_empty &&
                  (state_q == IDLE || state_q == GET_ADDR || state_q == GET_DATA);
  assign to_hit = rx_empty && (cnt_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    mode_wr_d   = mode_wr_q;
    cnt_d       = '0;
    w_data_d    = w_data_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          if (r_data == CMD_WR) begin
            mode_wr_d = 1'b1;
            state_d   = GET_ADDR;
          end else if (r_data == CMD_RD) begin
            mode_wr_d = 1'b0;
            state_d   = GET_ADDR;
          end else begin
            w_data_d    = RSP_NAK;
            frame_err_d = 1'b1;
            state_d     = SEND;
          end
        end
      end
      GET_ADDR: begin
        if (pop) begin
          reg_addr_d = r_data;
          if (mode_wr_q) begin
            state_d = GET_DATA;
          end else begin
            reg_re_d = 1'b1;
            state_d  = BUS_RD;
          end
        end else if (to_hit) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GET_DATA: begin
        if (pop) begin
          reg_wdata_d = r_data;
          reg_we_d    = 1'b1;
          state_d     = BUS_WR;
        end else if (to_hit) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BUS_WR: begin
        w_data_d = RSP_ACK;
        state_d  = SEND;
      end
      BUS_RD:  state_d = RD_WAIT;
      RD_WAIT: begin
        w_data_d = reg_rdata;
        state_d  = SEND;
      end
      SEND: begin
        if (!tx_full) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_wr_q   <= 1'b0;
      cnt_q       <= '0;
      w_data_q    <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_wr_q   <= mode_wr_d;
      cnt_q       <= cnt_d;
      w_data_q    <= w_data_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rd_uart   = pop;
  assign wr_uart   = !rst && (state_q == SEND) && !tx_full;
  assign w_data    = w_data_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Bench for uart_reg_bridge: FIFO/bus models, vector table, corner sequences
// and a randomized frame stream checked against a protocol-level model.
module tb_uart_reg_bridge;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst, rx_empty, tx_full;
  logic [7:0] r_data, reg_rdata;
  logic       rd_uart, wr_uart, reg_we, reg_re, busy, frame_err;
  logic [7:0] w_data, reg_addr, reg_wdata;

  always #5 clk = ~clk;

  uart_reg_bridge #(.TIMEOUT(TO), .TO_BIT(5)) dut (
    .clk(clk), .rst(rst), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .tx_full(tx_full), .w_data(w_data), .wr_uart(wr_uart), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
    .busy(busy), .frame_err(frame_err)
  );

  logic [7:0] rxq[$];
  logic [7:0] mem[256];
  logic [7:0] mmem[256];
  logic [7:0] tx_log[$];
  int         tx_cyc[$];
  int         cyc, we_n, re_n, err_n, we_cyc, re_cyc, err_cyc, pop_cyc;
  logic [7:0] we_addr, we_data, re_addr;
  logic       s_p, s_pw, s_we, s_re;
  logic [7:0] s_wd, s_wa, s_wdt;
  int         passed = 0, total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] txb(input int i);
    return (tx_log.size() > i) ? {24'h0, tx_log[i]} : 32'hxxxxxxxx;
  endfunction

  // FIFO and register-bus models: sample at negedge, apply just after posedge.
  initial begin
    rx_empty = 1'b1; r_data = 8'h00; reg_rdata = 8'h00; cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      s_p = rd_uart; s_pw = wr_uart; s_wd = w_data; s_we = reg_we;
      s_re = reg_re; s_wa = reg_addr; s_wdt = reg_wdata;
      if (s_pw) begin tx_log.push_back(s_wd); tx_cyc.push_back(cyc); end
      if (s_we) begin we_n++; we_addr = s_wa; we_data = s_wdt; we_cyc = cyc; end
      if (s_re) begin re_n++; re_addr = s_wa; re_cyc = cyc; end
      if (frame_err) begin err_n++; err_cyc = cyc; end
      if (s_p) pop_cyc = cyc;
      @(posedge clk); #1;
      if (s_p && rxq.size() > 0) void'(rxq.pop_front());
      if (s_we) mem[s_wa] = s_wdt;
      if (s_re) reg_rdata = mem[s_wa];
      rx_empty = (rxq.size() == 0);
      r_data   = rx_empty ? 8'h00 : rxq[0];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #3; end
  endtask

  task automatic clear_logs();
    tx_log.delete(); tx_cyc.delete();
    we_n = 0; re_n = 0; err_n = 0;
  endtask

  task automatic wait_tx(input int n, input int bound);
    int k = 0;
    while (tx_log.size() < n && k < bound) begin tick(1); k++; end
  endtask

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         nb;
    logic [7:0] tx;
    int         we, re, err;
    logic [7:0] addr, wdata;
  } vec_t;

  vec_t vt[9];

  initial begin
    int bad, nexp, mis;
    logic [7:0] exp_tx[$];
    logic [7:0] a, d, c;
    int exp_err;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h22] = 8'h3C;
    we_n = 0; re_n = 0; err_n = 0; we_cyc = 0; re_cyc = 0; err_cyc = 0; pop_cyc = 0;
    we_addr = 0; we_data = 0; re_addr = 0;
    tx_full = 1'b0;
    rst = 1'b1;

    // Reset: rx data waiting must not be popped while rst is high.
    rxq.push_back(8'h41);
    tick(3);
    chk("rst_rd_uart", {31'h0, rd_uart}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    rxq.delete();
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("rst_outputs", {w_data, reg_addr, reg_wdata, 4'h0, reg_we, reg_re, frame_err, wr_uart}, 0);
    chk("rst_busy_after", {31'h0, busy}, 0);

    vt[0] = '{8'h57, 8'h10, 8'hA5, 3, 8'h4B, 1, 0, 0, 8'h10, 8'hA5};
    vt[1] = '{8'h52, 8'h22, 8'h00, 2, 8'h3C, 0, 1, 0, 8'h22, 8'h00};
    vt[2] = '{8'h41, 8'h00, 8'h00, 1, 8'h45, 0, 0, 1, 8'h00, 8'h00};
    vt[3] = '{8'h52, 8'h10, 8'h00, 2, 8'hA5, 0, 1, 0, 8'h10, 8'h00};
    vt[4] = '{8'h57, 8'hFF, 8'h00, 3, 8'h4B, 1, 0, 0, 8'hFF, 8'h00};
    vt[5] = '{8'h52, 8'hFF, 8'h00, 2, 8'h00, 0, 1, 0, 8'hFF, 8'h00};
    vt[6] = '{8'h4B, 8'h00, 8'h00, 1, 8'h45, 0, 0, 1, 8'h00, 8'h00};
    vt[7] = '{8'h57, 8'h00, 8'hFF, 3, 8'h4B, 1, 0, 0, 8'h00, 8'hFF};
    vt[8] = '{8'h52, 8'h00, 8'h00, 2, 8'hFF, 0, 1, 0, 8'h00, 8'h00};

    for (int i = 0; i < 9; i++) begin
      clear_logs();
      rxq.push_back(vt[i].b0);
      if (vt[i].nb > 1) rxq.push_back(vt[i].b1);
      if (vt[i].nb > 2) rxq.push_back(vt[i].b2);
      wait_tx(1, 60);
      tick(3);
      chk($sformatf("v%0d_txn", i), tx_log.size(), 1);
      chk($sformatf("v%0d_tx", i), txb(0), {24'h0, vt[i].tx});
      chk($sformatf("v%0d_we", i), we_n, vt[i].we);
      chk($sformatf("v%0d_re", i), re_n, vt[i].re);
      chk($sformatf("v%0d_err", i), err_n, vt[i].err);
      chk($sformatf("v%0d_busy", i), {31'h0, busy}, 0);
      if (vt[i].we > 0) begin
        chk($sformatf("v%0d_waddr", i), {24'h0, we_addr}, {24'h0, vt[i].addr});
        chk($sformatf("v%0d_wdata", i), {24'h0, we_data}, {24'h0, vt[i].wdata});
        if (tx_cyc.size() > 0) chk($sformatf("v%0d_wlat", i), tx_cyc[0] - we_cyc, 1);
      end
      if (vt[i].re > 0) begin
        chk($sformatf("v%0d_raddr", i), {24'h0, re_addr}, {24'h0, vt[i].addr});
        if (tx_cyc.size() > 0) chk($sformatf("v%0d_rlat", i), tx_cyc[0] - re_cyc, 2);
      end
    end

    // Back-pressure: response held, later bytes left in the FIFO.
    clear_logs();
    tx_full = 1'b1;
    rxq.push_back(8'h57); rxq.push_back(8'h10); rxq.push_back(8'hA5);
    tick(6);
    rxq.push_back(8'h52); rxq.push_back(8'h10);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      tick(1);
      if (wr_uart || !busy || rxq.size() != 2 || rd_uart) bad++;
    end
    chk("bp_hold", bad, 0);
    chk("bp_we", we_n, 1);
    tx_full = 1'b0;
    wait_tx(2, 60);
    tick(3);
    chk("bp_txn", tx_log.size(), 2);
    chk("bp_tx0", txb(0), 32'h4B);
    chk("bp_tx1", txb(1), 32'hA5);

    // Timeout after the address byte.
    clear_logs();
    rxq.push_back(8'h57); rxq.push_back(8'h10);
    for (int k = 0; k < 40 && err_n == 0; k++) tick(1);
    tick(3);
    chk("to_err", err_n, 1);
    chk("to_lat", err_cyc - pop_cyc, TO);
    chk("to_tx", tx_log.size(), 0);
    chk("to_strobe", we_n + re_n, 0);
    chk("to_busy", {31'h0, busy}, 0);
    clear_logs();
    rxq.push_back(8'h52); rxq.push_back(8'h10);
    wait_tx(1, 60);
    tick(3);
    chk("to_after_rd", txb(0), 32'hA5);
    chk("to_after_err", err_n, 0);

    // Back-to-back frames preloaded.
    clear_logs();
    rxq.push_back(8'h57); rxq.push_back(8'h01); rxq.push_back(8'h11);
    rxq.push_back(8'h52); rxq.push_back(8'h01);
    wait_tx(2, 80);
    tick(3);
    chk("b2b_txn", tx_log.size(), 2);
    chk("b2b_tx0", txb(0), 32'h4B);
    chk("b2b_tx1", txb(1), 32'h11);
    chk("b2b_strobes", {we_n[15:0], re_n[15:0]}, 32'h0001_0001);
    chk("b2b_order", {31'h0, we_cyc < re_cyc}, 1);

    // Reset in the middle of a frame.
    clear_logs();
    rxq.push_back(8'h57); rxq.push_back(8'h20);
    tick(4);
    chk("mid_busy_pre", {31'h0, busy}, 1);
    rst = 1'b1;
    tick(1);
    chk("mid_busy", {31'h0, busy}, 0);
    rst = 1'b0;
    tick(3);
    chk("mid_quiet", we_n + re_n + tx_log.size(), 0);

    // Random frame stream vs protocol model.
    for (int i = 0; i < 256; i++) mmem[i] = mem[i];
    clear_logs();
    exp_err = 0;
    for (int f = 0; f < 40; f++) begin
      a = 8'($urandom_range(0, 7));
      d = 8'($urandom);
      case ($urandom_range(0, 2))
        0: begin
          rxq.push_back(8'h57); rxq.push_back(a); rxq.push_back(d);
          mmem[a] = d; exp_tx.push_back(8'h4B);
        end
        1: begin
          rxq.push_back(8'h52); rxq.push_back(a);
          exp_tx.push_back(mmem[a]);
        end
        default: begin
          c = 8'($urandom);
          while (c == 8'h57 || c == 8'h52) c = 8'($urandom);
          rxq.push_back(c);
          exp_tx.push_back(8'h45); exp_err++;
        end
      endcase
    end
    nexp = exp_tx.size();
    for (int k = 0; k < 3000 && tx_log.size() < nexp; k++) begin
      tx_full = ($urandom_range(0, 3) == 0);
      tick(1);
    end
    tx_full = 1'b0;
    tick(4);
    chk("rnd_txn", tx_log.size(), nexp);
    for (int i = 0; i < nexp; i++) chk($sformatf("rnd_tx%0d", i), txb(i), {24'h0, exp_tx[i]});
    chk("rnd_err", err_n, exp_err);
    mis = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== mmem[i]) mis++;
    chk("rnd_mem", mis, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
